// File: rtl/serial_full_adder.sv
// Bit-serial W-bit adder: one full-adder slice plus carry flop, LSB first.
// Optional SERIAL_ADD_OVF_EN adds a registered signed-overflow output V.
//
// state | meaning
// IDLE  | waiting for start; S/Co (and V) hold the last result
// RUN   | one bit of A+B+carry per clock, W cycles
// DONE  | one-cycle done pulse, result registered
module serial_full_adder #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         Cin,
    output logic [W-1:0] S,
    output logic         Co,
`ifdef SERIAL_ADD_OVF_EN
    output logic         V,
`endif
    output logic         busy,
    output logic         done
);

    localparam int CW = $clog2(W) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   opa_q, opa_d;
    logic [W-1:0]   opb_q, opb_d;
    logic [W-1:0]   acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           carry_q, carry_d;
    logic [W-1:0]   s_q, s_d;
    logic           co_q, co_d;
    logic           v_q, v_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           sum_bit;
    logic           carry_nxt;

    assign sum_bit   = opa_q[0] ^ opb_q[0] ^ carry_q;
    assign carry_nxt = (opa_q[0] & opb_q[0]) | (opa_q[0] & carry_q) | (opb_q[0] & carry_q);

    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        s_d     = s_q;
        co_d    = co_q;
        v_d     = v_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    opa_d   = A;
                    opb_d   = B;
                    carry_d = Cin;
                    cnt_d   = '0;
                    acc_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                // New bit enters at the MSB; after W shifts bit 0 sits at the LSB.
                acc_d   = (acc_q >> 1) | (W'(sum_bit) << (W - 1));
                opa_d   = opa_q >> 1;
                opb_d   = opb_q >> 1;
                carry_d = carry_nxt;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) begin
                    s_d     = acc_d;
                    co_d    = carry_nxt;
                    v_d     = carry_q ^ carry_nxt;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            s_q     <= '0;
            co_q    <= 1'b0;
            v_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            s_q     <= s_d;
            co_q    <= co_d;
            v_q     <= v_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign S    = s_q;
    assign Co   = co_q;
    assign busy = busy_q;
    assign done = done_q;
`ifdef SERIAL_ADD_OVF_EN
    assign V    = v_q;
`else
    logic unused_v;
    assign unused_v = v_q;
`endif

endmodule
